// File: rtl/m65c02_mpc_pkg.sv
// Shared microprogram definitions for the M65C02A sequencer and microcycle controller:
// sequencer instruction encodings and microword field layout.
package m65c02_mpc_pkg;

    typedef enum logic [3:0] {
        RTS  = 4'd0,  BSR  = 4'd1,  FTCH = 4'd2,  BMW  = 4'd3,
        BRV0 = 4'd4,  BRV1 = 4'd5,  BRV2 = 4'd6,  BRV3 = 4'd7,
        BTH0 = 4'd8,  BTH1 = 4'd9,  BTH2 = 4'd10, BTH3 = 4'd11,
        BTL0 = 4'd12, BTL1 = 4'd13, BTL2 = 4'd14, BTL3 = 4'd15
    } seq_instr_t;

    // Instruction held on I while reset is active
    localparam logic [3:0] C_RST_I = FTCH;

    // Field positions; the *_OFS fields sit above BA, so they are offsets from pAddrWidth
    localparam int MW_I_LSB   = 0;
    localparam int MW_I_W     = 4;
    localparam int MW_BA_LSB  = 4;
    localparam int MW_LEN_OFS = 4;
    localparam int MW_LEN_W   = 2;
    localparam int MW_MEM_OFS = 6;
    localparam int MW_CTL_OFS = 7;

endpackage

// File: rtl/m65c02_ucycle_wdt.sv
// Memory-handshake watchdog: counts wait clocks and flags the clock on which the wait
// limit is reached.
module m65c02_ucycle_wdt #(
    parameter int pTimeout = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    input  logic Run,
    output logic TO
);

    logic [9:0] wcnt_r;

    // Wait counter: cleared by reset or Clr, advances only while a request is unanswered
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wcnt_r <= 10'd0;
        end else if (Clr) begin
            wcnt_r <= 10'd0;
        end else if (Run) begin
            wcnt_r <= wcnt_r + 10'd1;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    assign TO = Run & (wcnt_r == 10'(pTimeout - 1));

endmodule

// File: rtl/m65c02_ucycle_ctl.sv
// Microcycle controller: drives the microprogram ROM from the sequencer address, splits the
// microword into fields and generates Rdy from length, memory handshake and Hold.
module m65c02_ucycle_ctl
    import m65c02_mpc_pkg::*;
#(
    parameter int pAddrWidth = 10,
    parameter int pWordWidth = 32,
    parameter int pTimeout   = 255
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic [pAddrWidth-1:0]               MA,
    output logic [pAddrWidth-1:0]               ROM_Addr,
    output logic                                ROM_En,
    input  logic [pWordWidth-1:0]               ROM_Data,
    input  logic                                Hold,
    input  logic                                Mem_Ack,
    output logic                                Rdy,
    output logic [3:0]                          I,
    output logic [pAddrWidth-1:0]               BA,
    output logic [pWordWidth-pAddrWidth-8:0]    Ctl,
    output logic                                Mem_Req,
    output logic                                CycStart,
    output logic                                Bus_Err
);

    logic       drst_r;
    logic [1:0] cnt_r;
    logic       ack_seen_r;
    logic       cyc_start_r;

    logic       rst_act_s;
    logic [1:0] cyc_len_s;
    logic       mem_fld_s;
    logic       len_done_s;
    logic       mem_req_s;
    logic       ack_hit_s;
    logic       to_s;
    logic       mem_done_s;
    logic       rdy_s;

    assign rst_act_s  = Rst | drst_r;
    assign cyc_len_s  = ROM_Data[pAddrWidth+MW_LEN_OFS +: MW_LEN_W];
    assign mem_fld_s  = ROM_Data[pAddrWidth+MW_MEM_OFS];
    assign len_done_s = (cnt_r == cyc_len_s);
    assign mem_req_s  = mem_fld_s & ~ack_seen_r & ~rst_act_s;
    assign ack_hit_s  = mem_req_s & Mem_Ack;
    assign mem_done_s = ~mem_fld_s | ack_seen_r | ack_hit_s | to_s;
    assign rdy_s      = ~rst_act_s & len_done_s & mem_done_s & ~Hold;

    m65c02_ucycle_wdt #(
        .pTimeout (pTimeout)
    ) u_wdt (
        .Clk (Clk),
        .Rst (rst_act_s),
        .Clr (rdy_s | Mem_Ack),
        .Run (mem_req_s & ~Mem_Ack),
        .TO  (to_s)
    );

    // Reset stretch and start-of-microcycle marker
    always_ff @(posedge Clk) begin
        drst_r <= Rst;
        if (Rst) begin
            cyc_start_r <= 1'b0;
        end else begin
            cyc_start_r <= drst_r | rdy_s;
        end
    end

    // Length counter stops once it reaches CycLen, so LenDone stays true while the
    // handshake or Hold stretches the microcycle
    always_ff @(posedge Clk) begin
        if (rst_act_s || rdy_s) begin
            cnt_r <= 2'd0;
        end else if (cnt_r != cyc_len_s) begin
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Handshake completion flag; a watchdog timeout counts as a completion
    always_ff @(posedge Clk) begin
        if (rst_act_s || rdy_s) begin
            ack_seen_r <= 1'b0;
        end else if (ack_hit_s || to_s) begin
            ack_seen_r <= 1'b1;
        end else begin
            ack_seen_r <= ack_seen_r;
        end
    end

    // Microword field split, forced to a FTCH with empty fields during reset
    always_comb begin
        I   = C_RST_I;
        BA  = '0;
        Ctl = '0;
        if (rst_act_s) begin
            I   = C_RST_I;
            BA  = '0;
            Ctl = '0;
        end else begin
            I   = ROM_Data[MW_I_LSB +: MW_I_W];
            BA  = ROM_Data[MW_BA_LSB +: pAddrWidth];
            Ctl = ROM_Data[pWordWidth-1:pAddrWidth+MW_CTL_OFS];
        end
    end

    assign ROM_Addr = MA;
    assign ROM_En   = rdy_s | rst_act_s;
    assign Rdy      = rdy_s;
    assign Mem_Req  = mem_req_s;
    assign Bus_Err  = to_s;
    assign CycStart = cyc_start_r & ~rst_act_s;

endmodule

// File: tb/tb_m65c02_ucycle_ctl.sv
// Scoreboard bench for m65c02_ucycle_ctl: per-microcycle expectations from a timing model,
// checked against DUT outputs by an independent monitor.
module tb_m65c02_ucycle_ctl;

    localparam int AW  = 10;
    localparam int WW  = 32;
    localparam int TMO = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] MA;
    logic [AW-1:0] ROM_Addr;
    logic          ROM_En;
    logic [WW-1:0] ROM_Data;
    logic          Hold;
    logic          Mem_Ack;
    logic          Rdy;
    logic [3:0]    I;
    logic [AW-1:0] BA;
    logic [WW-AW-8:0] Ctl;
    logic          Mem_Req;
    logic          CycStart;
    logic          Bus_Err;

    m65c02_ucycle_ctl #(.pAddrWidth(AW), .pWordWidth(WW), .pTimeout(TMO)) dut (
        .Clk(Clk), .Rst(Rst), .MA(MA), .ROM_Addr(ROM_Addr), .ROM_En(ROM_En),
        .ROM_Data(ROM_Data), .Hold(Hold), .Mem_Ack(Mem_Ack), .Rdy(Rdy), .I(I), .BA(BA),
        .Ctl(Ctl), .Mem_Req(Mem_Req), .CycStart(CycStart), .Bus_Err(Bus_Err)
    );

    always #5 Clk = ~Clk;

    logic [WW-1:0] rom [0:1023];
    logic [WW-1:0] rom_q;

    always @(posedge Clk) begin
        if (ROM_En) rom_q <= rom[ROM_Addr];
    end
    assign ROM_Data = rom_q;

    typedef struct {
        logic [AW-1:0] addr;
        int            rdy_clk;
        int            mrq;
        int            be;
    } exp_t;

    exp_t          sb[$];
    exp_t          hd;
    int            checks = 0;
    int            errors = 0;
    int            pos = 1;
    logic          mon_en = 1'b0;
    logic [AW-1:0] cur_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] mkword(input int len, input int mem);
        logic [WW-1:0] w;
        w = $urandom;
        w[15:14] = 2'(len);
        w[16] = 1'(mem);
        return w;
    endfunction

    task automatic reset_checks();
        chk("rst_rom_en", 32'(ROM_En), 32'd1);
        chk("rst_rdy", 32'(Rdy), 32'd0);
        chk("rst_mem_req", 32'(Mem_Req), 32'd0);
        chk("rst_cycstart", 32'(CycStart), 32'd0);
        chk("rst_bus_err", 32'(Bus_Err), 32'd0);
        chk("rst_i", 32'(I), 32'h2);
        chk("rst_ba", 32'(BA), 32'd0);
        chk("rst_ctl", 32'(Ctl), 32'd0);
    endtask

    // One microcycle: the length is the latest of length, handshake and Hold release
    task automatic run_ucycle(input logic [AW-1:0] nxt, input int ack_clk, input int hold_rel);
        logic [WW-1:0] w;
        int len, md, mrq, be, rc;
        exp_t e;
        w = rom[cur_addr];
        len = int'(w[15:14]) + 1;
        if (w[16]) begin
            if (ack_clk >= 1 && ack_clk <= TMO) begin
                md = ack_clk; mrq = ack_clk; be = 0;
            end else begin
                md = TMO; mrq = TMO; be = TMO;
            end
        end else begin
            md = 1; mrq = 0; be = 0;
        end
        rc = len;
        if (md > rc) rc = md;
        if (hold_rel > rc) rc = hold_rel;
        e.addr = cur_addr; e.rdy_clk = rc; e.mrq = mrq; e.be = be;
        sb.push_back(e);
        for (int k = 1; k <= rc; k++) begin
            MA   = nxt;
            Hold = (k < hold_rel);
            if (w[16]) Mem_Ack = (k == ack_clk) || (k > mrq && $urandom_range(0, 1) == 1);
            else       Mem_Ack = ($urandom_range(0, 1) == 1);
            @(posedge Clk); #1;
        end
        cur_addr = nxt;
    endtask

    // Monitor: compares every clock against the head expectation, pops on Rdy
    always @(negedge Clk) begin
        if (!mon_en) begin
            pos = 1;
        end else begin
            chk("rom_addr", 32'(ROM_Addr), 32'(MA));
            chk("cycstart", 32'(CycStart), 32'(pos == 1));
            chk("rom_en", 32'(ROM_En), 32'(Rdy));
            if (sb.size() == 0) begin
                chk("rdy_unexpected", 32'(Rdy), 32'd0);
            end else begin
                hd = sb[0];
                chk("mem_req", 32'(Mem_Req), 32'(pos <= hd.mrq));
                chk("bus_err", 32'(Bus_Err), 32'(pos == hd.be));
                chk("rdy", 32'(Rdy), 32'(pos == hd.rdy_clk));
                if (Rdy || pos >= hd.rdy_clk) begin
                    chk("field_i", 32'(I), 32'(rom[hd.addr][3:0]));
                    chk("field_ba", 32'(BA), 32'(rom[hd.addr][13:4]));
                    chk("field_ctl", 32'(Ctl), 32'(rom[hd.addr][31:17]));
                    void'(sb.pop_front());
                    pos = 1;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = mkword($urandom_range(0, 3), $urandom_range(0, 1));
        rom[10'h000] = mkword(0, 0);
        rom[10'h010] = mkword(0, 0);
        rom[10'h011] = mkword(0, 0);
        rom[10'h012] = mkword(0, 0);
        rom[10'h020] = mkword(3, 0);
        rom[10'h030] = mkword(0, 1);
        rom[10'h031] = mkword(0, 1);
        rom[10'h040] = mkword(0, 1);
        rom[10'h050] = mkword(1, 0);
        rom[10'h060] = mkword(0, 1);

        Rst = 1'b1; MA = '0; Hold = 1'b0; Mem_Ack = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            reset_checks();
        end
        Rst = 1'b0; Mem_Ack = 1'b0;
        #1;
        reset_checks();
        @(posedge Clk); #1;
        cur_addr = '0;
        mon_en = 1'b1;

        run_ucycle(10'h010, 0, 1);
        run_ucycle(10'h011, 0, 1);
        run_ucycle(10'h012, 0, 1);
        run_ucycle(10'h020, 0, 1);
        run_ucycle(10'h030, 0, 1);
        run_ucycle(10'h031, 0, 1);
        run_ucycle(10'h040, 3, 1);
        run_ucycle(10'h050, 1, 1);
        run_ucycle(10'h100, 0, 1);
        run_ucycle(10'h101, 0, 6);
        for (int n = 0; n < 300; n++) begin
            run_ucycle(10'($urandom_range(10'h100, 10'h3FF)), $urandom_range(0, 6),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : 1);
        end
        run_ucycle(10'h060, 0, 1);

        // Reset in the middle of a handshake abandons the request at once
        mon_en = 1'b0; Hold = 1'b0; Mem_Ack = 1'b0;
        #1;
        chk("pre_rst_mem_req", 32'(Mem_Req), 32'd1);
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(Mem_Req), 32'd0);
        chk("mid_rst_bus_err", 32'(Bus_Err), 32'd0);
        chk("mid_rst_rdy", 32'(Rdy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
